// File: rtl/axha_pipe_adder_if.sv
// Operand/result stream bundle for the approximate adder.
// The slave view belongs to the adder; the master view belongs to whoever
// feeds operands and consumes results.
interface axha_pipe_adder_if #(
  parameter int WIDTH = 16,
  parameter int LW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic [LW-1:0]    in_level;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_exact;
  logic             out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_level, out_ready,
    output in_ready, out_valid, out_sum, out_exact, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, in_level, out_ready,
    input  in_ready, out_valid, out_sum, out_exact, out_err
  );
endinterface

// File: rtl/axha_pipe_adder.sv
// Two-stage pipelined approximate adder with a runtime approximation level.
// The low Le bits of the sum are a|b; the carry into the exact upper part
// is a[Le-1]&b[Le-1]. The exact sum travels alongside so an error monitor
// can accumulate statistics on every transferred result.
module axha_pipe_adder #(
  parameter int WIDTH     = 16,
  parameter int LEVEL_MAX = 8,
  parameter int LW        = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  axha_pipe_adder_if.slave     bus,
  input  logic                 stat_clr,
  output logic [31:0]          stat_samples,
  output logic [31:0]          stat_errors,
  output logic [WIDTH:0]       stat_max_err
);

  typedef logic [WIDTH:0] sum_t;

  localparam logic [LW-1:0] LEVEL_CAP = LW'(LEVEL_MAX);

  // Approximate sum at effective level le (le=0 means exact).
  function automatic sum_t approx_add(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [LW-1:0]    le);
    sum_t low_mask;
    sum_t a_hi;
    sum_t b_hi;
    sum_t hi;
    logic carry;
    low_mask = '0;
    carry    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(le))      low_mask[i] = 1'b1;
      if (i + 1 == int'(le)) carry       = a[i] & b[i];
    end
    a_hi = {1'b0, a} >> le;
    b_hi = {1'b0, b} >> le;
    hi   = a_hi + b_hi + sum_t'(carry);
    return (hi << le) | (({1'b0, a} | {1'b0, b}) & low_mask);
  endfunction

  // Pipeline state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [LW-1:0]    s1_le;
  logic             s2_valid;
  sum_t             s2_sum;
  sum_t             s2_exact;
  logic             s2_err;

  logic             adv1;
  logic             adv2;
  logic [LW-1:0]    in_le;
  sum_t             s1_approx;
  sum_t             s1_exact_sum;
  logic             xfer;
  sum_t             abs_err;

  // A stage advances when it is empty or its successor is advancing; the
  // ready chain starts at out_ready, so in_ready never depends on in_valid.
  assign adv2        = !s2_valid || bus.out_ready;
  assign adv1        = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  assign bus.out_valid = s2_valid;
  assign bus.out_sum   = s2_sum;
  assign bus.out_exact = s2_exact;
  assign bus.out_err   = s2_err;

  // Effective level: exact mode forces 0, otherwise clamp to LEVEL_MAX.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    in_le = '0;
    if (bus.in_mode) in_le = (bus.in_level > LEVEL_CAP) ? LEVEL_CAP : bus.in_level;
  end

  // Stage 1: capture operands and effective level.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_le    <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_le <= in_le;
      end
    end
  end

  assign s1_approx    = approx_add(s1_a, s1_b, s1_le);
  assign s1_exact_sum = {1'b0, s1_a} + {1'b0, s1_b};

  // Stage 2: register selected sum, exact sum and error flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_exact <= '0;
      s2_err   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum   <= s1_approx;
        s2_exact <= s1_exact_sum;
        s2_err   <= (s1_approx != s1_exact_sum);
      end
    end
  end

  assign xfer    = s2_valid && bus.out_ready;
  assign abs_err = (s2_exact >= s2_sum) ? (s2_exact - s2_sum) : (s2_sum - s2_exact);

  // Error monitor: counts only transferred results; clear beats a transfer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || stat_clr) begin
      stat_samples <= '0;
      stat_errors  <= '0;
      stat_max_err <= '0;
    end else if (xfer) begin
      if (stat_samples != 32'hFFFF_FFFF) stat_samples <= stat_samples + 32'd1;
      if (s2_err && stat_errors != 32'hFFFF_FFFF) stat_errors <= stat_errors + 32'd1;
      if (abs_err > stat_max_err) stat_max_err <= abs_err;
    end
  end

endmodule

// File: tb/tb_axha_pipe_adder.sv
// Self-checking bench for axha_pipe_adder: directed corner beats, a stall
// scenario, randomized traffic against an arithmetic reference model, and a
// reset with both stages full.
module tb_axha_pipe_adder;

  localparam int WIDTH     = 16;
  localparam int LEVEL_MAX = 8;
  localparam int LW        = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stat_clr = 1'b0;
  logic [31:0]        stat_samples;
  logic [31:0]        stat_errors;
  logic [WIDTH:0]     stat_max_err;

  axha_pipe_adder_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

  axha_pipe_adder #(.WIDTH(WIDTH), .LEVEL_MAX(LEVEL_MAX), .LW(LW)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .bus          (bus.slave),
    .stat_clr     (stat_clr),
    .stat_samples (stat_samples),
    .stat_errors  (stat_errors),
    .stat_max_err (stat_max_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned sum;
    int unsigned exact;
    bit          err;
  } exp_t;

  exp_t        q[$];
  int unsigned m_samples, m_errors, m_max;
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  bit          held_valid = 1'b0;
  logic [63:0] held;
  logic [15:0] ta [5];
  logic [15:0] tb [5];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the approximation rule.
  function automatic exp_t ref_model(input int unsigned a, input int unsigned b,
                                     input bit mode, input int unsigned level);
    exp_t        e;
    int unsigned le, p, low, c, hi;
    le = mode ? ((level > LEVEL_MAX) ? LEVEL_MAX : level) : 0;
    e.exact = a + b;
    if (le == 0) begin
      e.sum = a + b;
    end else begin
      p     = 1 << le;
      low   = (a | b) % p;
      c     = ((a >> (le - 1)) & 1) & ((b >> (le - 1)) & 1);
      hi    = a / p + b / p + c;
      e.sum = hi * p + low;
    end
    e.err = (e.sum != e.exact);
    return e;
  endfunction

  // One clock: observe handshakes with current inputs, update model, advance.
  task automatic step();
    bit          acc, xfer;
    exp_t        e;
    int unsigned d;
    #1;
    acc  = bus.in_valid && bus.in_ready;
    xfer = bus.out_valid && bus.out_ready;
    if (held_valid)
      check("stall_hold", 64'({bus.out_valid, bus.out_sum, bus.out_exact, bus.out_err}), held);
    check("stat_samples", stat_samples, m_samples);
    check("stat_errors", stat_errors, m_errors);
    check("stat_max_err", stat_max_err, m_max);
    if (rst) begin
      q.delete();
      m_samples = 0; m_errors = 0; m_max = 0;
      held_valid = 1'b0;
    end else begin
      if (xfer) begin
        if (q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_sum", bus.out_sum, e.sum);
          check("out_exact", bus.out_exact, e.exact);
          check("out_err", bus.out_err, e.err);
          if (!stat_clr) begin
            if (m_samples != 32'hFFFF_FFFF) m_samples++;
            if (e.err && m_errors != 32'hFFFF_FFFF) m_errors++;
            d = (e.exact >= e.sum) ? e.exact - e.sum : e.sum - e.exact;
            if (d > m_max) m_max = d;
          end
        end
      end
      if (stat_clr) begin
        m_samples = 0; m_errors = 0; m_max = 0;
      end
      if (acc) begin
        accepted++;
        q.push_back(ref_model(bus.in_a, bus.in_b, bus.in_mode, bus.in_level));
      end
      held_valid = bus.out_valid && !bus.out_ready;
      held = 64'({bus.out_valid, bus.out_sum, bus.out_exact, bus.out_err});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [15:0] a, input logic [15:0] b,
                          input logic mode, input logic [3:0] lvl);
    bus.in_a = a; bus.in_b = b; bus.in_mode = mode; bus.in_level = lvl;
  endtask

  // Send one beat with out_ready=1 and check the result two cycles later.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic mode, input logic [3:0] lvl,
                          input logic [16:0] exp_sum, input logic [16:0] exp_exact,
                          input logic exp_err);
    set_beat(a, b, mode, lvl);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    #1;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_sum"}, bus.out_sum, exp_sum);
    check({tag, "_exact"}, bus.out_exact, exp_exact);
    check({tag, "_err"}, bus.out_err, exp_err);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_samples = 0; m_errors = 0; m_max = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_beat(16'h0, 16'h0, 1'b0, 4'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_exact", bus.out_exact, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_samples", stat_samples, 0);

    // Corner beats and statistics over them.
    directed("t1", 16'h000F, 16'h0001, 1'b1, 4'd4, 17'h0000F, 17'h00010, 1'b1);
    directed("t2", 16'h00FF, 16'h00FF, 1'b1, 4'd8, 17'h001FF, 17'h001FE, 1'b1);
    directed("t3", 16'hFFFF, 16'hFFFF, 1'b0, 4'd5, 17'h1FFFE, 17'h1FFFE, 1'b0);
    #1;
    check("t5_samples", stat_samples, 3);
    check("t5_errors", stat_errors, 2);
    check("t5_max_err", stat_max_err, 1);
    directed("t2_clamp", 16'h00FF, 16'h00FF, 1'b1, 4'd12, 17'h001FF, 17'h001FE, 1'b1);
    directed("t3_l0", 16'hFFFF, 16'hFFFF, 1'b1, 4'd0, 17'h1FFFE, 17'h1FFFE, 1'b0);

    // Clear concurrent with a transfer: the beat is not counted.
    set_beat(16'h000F, 16'h0001, 1'b1, 4'd4);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #1;
    check("clr_samples", stat_samples, 0);
    check("clr_errors", stat_errors, 0);
    check("clr_max_err", stat_max_err, 0);

    // Stall: five back-to-back beats against a blocked consumer.
    for (int i = 0; i < 5; i++) begin
      ta[i] = 16'($urandom);
      tb[i] = 16'($urandom);
    end
    accepted = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      set_beat(ta[accepted], tb[accepted], 1'b1, 4'(3 + accepted));
      step();
    end
    #1;
    check("t4_accepted", accepted, 2);
    check("t4_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && (accepted < 5 || q.size() != 0); i++) begin
      bus.in_valid = (accepted < 5);
      if (accepted < 5) set_beat(ta[accepted], tb[accepted], 1'b1, 4'(3 + accepted));
      step();
    end
    check("t4_all_accepted", accepted, 5);
    check("t4_drained", q.size(), 0);

    // Randomized traffic with random back-pressure and occasional clears.
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      stat_clr      = ($urandom_range(0, 49) == 0);
      set_beat(($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
               ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
               1'($urandom), 4'($urandom_range(0, 15)));
      step();
    end
    stat_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    check("rand_drained", q.size(), 0);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(16'($urandom), 16'($urandom), 1'b1, 4'd6);
      step();
    end
    #1;
    check("t6_full_valid", bus.out_valid, 1);
    check("t6_full_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_samples", stat_samples, 0);
    check("t6_max_err", stat_max_err, 0);
    check("t6_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (6) step();
    #1;
    check("t6_no_stale", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
